sevenseg_arbiter: RTL and testbench

//   Shares the 8-digit seven-segment display between NUM_REQ requesters, e.g. a score readout,
//   a debug counter and a status message. Each requester presents a full 8-digit frame and

---
 rtl/sevenseg_pkg.sv | 36 +++
 rtl/sevenseg_arbiter_rr_pick.sv | 45 ++++
 rtl/sevenseg_arbiter.sv | 155 +++++++++++++++
 tb/tb_sevenseg_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// -----------------------------------------------------------------------------
// sevenseg_pkg
//   Shared types and constants for the seven-segment display modules.
//   Segment codes are active-low, bit order {dp, g, f, e, d, c, b, a}.
//   Contents:
//     seg_t        one digit's segment code
//     frame_t      eight digits, digit d = [8*d +: 8]
//     DIGITS[16]   hex glyphs 0..F (decimal point off)
//     DECIMAL      decimal point only
//     BLANK        all segments off
//     arb_state_t  arbiter FSM states
//     blank_frame  helper returning an all-blank frame
// -----------------------------------------------------------------------------
package sevenseg_pkg;

    typedef logic [7:0] seg_t;
    typedef seg_t [7:0] frame_t;

    localparam seg_t DECIMAL = 8'h7f;
    localparam seg_t BLANK   = 8'hff;

    localparam seg_t DIGITS [16] = '{
        8'hc0, 8'hf9, 8'ha4, 8'hb0, 8'h99, 8'h92, 8'h82, 8'hf8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hc6, 8'ha1, 8'h86, 8'h8e
    };

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_t;

    function automatic frame_t blank_frame();
        return {8{BLANK}};
    endfunction

endpackage

// File: rtl/sevenseg_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Scans ptr+1, ptr+2, ... (mod N) and
//   returns the first requester that is both requesting and enabled by mask.
//   Ports:
//     req    in   N          request bits
//     ptr    in   clog2(N)   index of the last winner; scanning starts after it
//     mask   in   N          1 = eligible, 0 = excluded from this pick
//     valid  out  1          some eligible requester was found
//     grant  out  N          one-hot winner, zero when valid=0
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic [N-1:0]         mask,
    output logic                 valid,
    output logic [N-1:0]         grant
);

    logic [N-1:0] eligible;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_elig
            assign eligible[gi] = req[gi] & mask[gi];
        end
    endgenerate

    // k runs 1..N so that the previous winner is considered last.
    always_comb begin
        int idx;
        idx   = 0;
        valid = 1'b0;
        grant = '0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!valid && eligible[idx]) begin
                valid      = 1'b1;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sevenseg_arbiter.sv
// -----------------------------------------------------------------------------
// sevenseg_arbiter
//   Shares one 8-digit seven-segment display between NUM_REQ requesters with
//   round-robin ownership and a minimum dwell time per owner, and generates the
//   display driver's strobe clock.
//   Ports:
//     CLOCK       in   1           system clock
//     RESET       in   1           asynchronous active-high reset
//     REQ         in   NUM_REQ     level request per requester
//     REQ_VALUE   in   NUM_REQ*64  frame of requester i = [64*i +: 64]
//     GRANT       out  NUM_REQ     one-hot owner, zero when idle
//     VALUE       out  64          frame forwarded to the display driver
//     STROBE_CLK  out  1           50% duty clock, period STROBE_DIV CLOCKs
// -----------------------------------------------------------------------------
module sevenseg_arbiter
    import sevenseg_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DWELL_CYCLES = 100_000_000,
    parameter int STROBE_DIV   = 2048
) (
    input  logic                   CLOCK,
    input  logic                   RESET,
    input  logic [NUM_REQ-1:0]     REQ,
    input  logic [NUM_REQ*64-1:0]  REQ_VALUE,
    output logic [NUM_REQ-1:0]     GRANT,
    output logic [63:0]            VALUE,
    output logic                   STROBE_CLK
);

    localparam int PTR_W   = $clog2(NUM_REQ);
    localparam int DWELL_W = $clog2(DWELL_CYCLES);
    localparam int HALF    = STROBE_DIV / 2;
    localparam int STR_W   = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [DWELL_W-1:0] DWELL_MAX  = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [STR_W-1:0]   STROBE_MAX = STR_W'(HALF - 1);
    localparam logic [PTR_W-1:0]   LAST_INIT  = PTR_W'(NUM_REQ - 1);

    arb_state_t           state_reg;
    logic [PTR_W-1:0]     last_reg;
    logic [DWELL_W-1:0]   dwell_reg;
    logic [NUM_REQ-1:0]   grant_reg;
    frame_t               value_reg;
    logic [STR_W-1:0]     strobe_cnt_reg;
    logic                 strobe_reg;

    frame_t               frames [NUM_REQ];
    logic [NUM_REQ-1:0]   pick_mask;
    logic                 pick_valid;
    logic [NUM_REQ-1:0]   pick_grant;
    logic [PTR_W-1:0]     win_idx;
    logic                 release_now;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_frames
            assign frames[gi] = REQ_VALUE[64*gi +: 64];
        end
    endgenerate

    // While owned, the owner is excluded so a release always moves elsewhere.
    // grant_reg is one-hot on last_reg in that state.
    always_comb begin
        pick_mask = '1;
        if (state_reg == ARB_OWNED) begin
            pick_mask = ~grant_reg;
        end
    end

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req   (REQ),
        .ptr   (last_reg),
        .mask  (pick_mask),
        .valid (pick_valid),
        .grant (pick_grant)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                win_idx = PTR_W'(i);
            end
        end
    end

    // Owner dropping its request wins over a dwell-expiry rotation; both end
    // in the same release path, so no explicit priority is needed.
    assign release_now = !REQ[last_reg] || ((dwell_reg == DWELL_MAX) && pick_valid);

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_reg <= ARB_IDLE;
            last_reg  <= LAST_INIT;
            dwell_reg <= '0;
            grant_reg <= '0;
            value_reg <= blank_frame();
        end else begin
            case (state_reg)
                ARB_IDLE: begin
                    value_reg <= blank_frame();
                    if (pick_valid) begin
                        grant_reg <= pick_grant;
                        last_reg  <= win_idx;
                        dwell_reg <= '0;
                        state_reg <= ARB_OWNED;
                    end
                end
                ARB_OWNED: begin
                    if (release_now) begin
                        if (pick_valid) begin
                            // Direct hand-over: new owner's frame appears on the same edge.
                            grant_reg <= pick_grant;
                            last_reg  <= win_idx;
                            dwell_reg <= '0;
                            value_reg <= frames[win_idx];
                        end else begin
                            grant_reg <= '0;
                            value_reg <= blank_frame();
                            state_reg <= ARB_IDLE;
                        end
                    end else begin
                        value_reg <= frames[last_reg];
                        if (dwell_reg != DWELL_MAX) begin
                            dwell_reg <= dwell_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= ARB_IDLE;
                    grant_reg <= '0;
                    value_reg <= blank_frame();
                end
            endcase
        end
    end

    // Free-running half-period counter; the strobe toggles on each wrap.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            strobe_cnt_reg <= '0;
            strobe_reg     <= 1'b0;
        end else if (strobe_cnt_reg == STROBE_MAX) begin
            strobe_cnt_reg <= '0;
            strobe_reg     <= ~strobe_reg;
        end else begin
            strobe_cnt_reg <= strobe_cnt_reg + 1'b1;
        end
    end

    assign GRANT      = grant_reg;
    assign VALUE      = value_reg;
    assign STROBE_CLK = strobe_reg;

endmodule

// File: tb/tb_sevenseg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sevenseg_arbiter
//   Scoreboard bench: the stimulus process applies REQ/REQ_VALUE on the falling
//   edge, advances a behavioural ownership model and queues the expected
//   outputs for the next rising edge; the monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_sevenseg_arbiter;

    localparam int N = 3;
    localparam int D = 8;
    localparam int S = 4;
    localparam logic [63:0] BLANK64 = 64'hffff_ffff_ffff_ffff;

    logic           CLOCK = 1'b0;
    logic           RESET = 1'b1;
    logic [N-1:0]   REQ = '0;
    logic [N*64-1:0] REQ_VALUE = '0;
    logic [N-1:0]   GRANT;
    logic [63:0]    VALUE;
    logic           STROBE_CLK;

    sevenseg_arbiter #(
        .NUM_REQ      (N),
        .DWELL_CYCLES (D),
        .STROBE_DIV   (S)
    ) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .REQ        (REQ),
        .REQ_VALUE  (REQ_VALUE),
        .GRANT      (GRANT),
        .VALUE      (VALUE),
        .STROBE_CLK (STROBE_CLK)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic [N-1:0] grant;
        logic [63:0]  value;
        logic         strobe;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_cyc   = 0;
    bit   running = 1'b1;

    // Reference model: owner index (-1 = nobody), last winner, cycles held,
    // and edges since reset for the strobe.
    int          m_owner = -1;
    int          m_last  = N - 1;
    int          m_held  = 0;
    int          m_edges = 0;
    logic [63:0] m_value = BLANK64;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int scan(input int last, input logic [N-1:0] r, input int excl);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (c != excl && r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_held  = 0;
        m_edges = 0;
        m_value = BLANK64;
    endtask

    task automatic drive(input logic [N-1:0] r);
        int   w;
        bit   rel;
        exp_t e;
        REQ = r;
        for (int i = 0; i < N * 2; i++) REQ_VALUE[32*i +: 32] = $urandom();
        if (m_owner < 0) begin
            m_value = BLANK64;
            w = scan(m_last, r, -1);
            if (w >= 0) begin
                m_owner = w; m_last = w; m_held = 0;
            end
        end else begin
            rel = !r[m_owner] || (m_held >= D - 1 && scan(m_last, r, m_owner) >= 0);
            if (rel) begin
                w = scan(m_last, r, m_owner);
                if (w >= 0) begin
                    m_owner = w; m_last = w; m_held = 0;
                    m_value = REQ_VALUE[64*w +: 64];
                end else begin
                    m_owner = -1;
                    m_value = BLANK64;
                end
            end else begin
                m_value = REQ_VALUE[64*m_owner +: 64];
                m_held++;
            end
        end
        m_edges++;
        e.grant  = (m_owner < 0) ? '0 : N'(1 << m_owner);
        e.value  = m_value;
        e.strobe = ((m_edges / (S / 2)) % 2) == 1;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [N-1:0] r);
        @(negedge CLOCK);
        drive(r);
    endtask

    task automatic hold(input logic [N-1:0] r, input int n);
        repeat (n) step(r);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge CLOCK);
            #1;
            if (!running) break;
            if (RESET) continue;
            n_cyc++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL scoreboard_empty: got no expectation, required one (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                $display("[TB] cyc %0d req=%b grant=%b value=%h strobe=%b", n_cyc, REQ, GRANT, VALUE, STROBE_CLK);
                check("grant",  64'(GRANT),      64'(e.grant));
                check("value",  VALUE,           e.value);
                check("strobe", 64'(STROBE_CLK), 64'(e.strobe));
            end
            check("grant_onehot0", 64'($onehot0(GRANT)), 64'd1);
            if (GRANT == '0) check("idle_blank", VALUE, BLANK64);
        end
    end

    // Stimulus
    initial begin
        logic [N-1:0] r;
        repeat (3) @(negedge CLOCK);
        RESET = 1'b0;
        model_reset();
        drive('0);

        hold(3'b000, 6);                    // idle, strobe only
        hold(3'b110, 4);                    // requester 1 wins from reset pointer
        hold(3'b000, 3);
        hold(3'b111, 30);                   // rotation with dwell
        hold(3'b010, 20);                   // lone owner past dwell
        hold(3'b110, 5);                    // late competitor
        hold(3'b000, 3);
        hold(3'b001, 2);                    // requester 0 takes ownership
        hold(3'b101, 3);
        hold(3'b100, 3);                    // owner drops before dwell
        hold(3'b000, 3);                    // last owner drops, idle
        hold(3'b111, 5);

        // Asynchronous reset between clock edges.
        @(posedge CLOCK);
        #3;
        RESET = 1'b1;
        #1;
        check("async_rst_grant",  64'(GRANT),      64'd0);
        check("async_rst_value",  VALUE,           BLANK64);
        check("async_rst_strobe", 64'(STROBE_CLK), 64'd0);
        @(negedge CLOCK);
        @(negedge CLOCK);
        RESET = 1'b0;
        model_reset();
        drive(3'b111);
        hold(3'b111, 10);

        // Randomised request patterns, held for a few cycles at a time.
        r = 3'b111;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) r = N'($urandom_range(0, 7));
            step(r);
        end
        hold(3'b000, 3);

        @(posedge CLOCK);
        #2;
        running = 1'b0;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

endmodule
